// File: rtl/gcm_tag_check_buffer_if.sv
// Signal bundle for gcm_tag_check_buffer: frame input, tag strobes and released output.
interface gcm_tag_check_buffer_if #(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 2
);
  localparam int NB_DATA = N_BLOCKS * NB_BLOCK;

  logic                i_valid;
  logic                i_sop;
  logic [NB_DATA-1:0]  i_plaintext_words_x;
  logic                i_valid_text;
  logic [NB_BLOCK-1:0] i_calc_tag;
  logic                i_calc_tag_valid;
  logic [NB_BLOCK-1:0] i_rx_tag;
  logic                i_rx_tag_valid;
  logic [NB_DATA-1:0]  o_plaintext_words_y;
  logic                o_valid_text;
  logic                o_sop;
  logic                o_eop;
  logic                o_tag_ok;
  logic                o_tag_fail;
  logic                o_overflow;
  logic                o_abort;
  logic                o_busy;

  modport slave (
    input  i_valid, i_sop, i_plaintext_words_x, i_valid_text,
           i_calc_tag, i_calc_tag_valid, i_rx_tag, i_rx_tag_valid,
    output o_plaintext_words_y, o_valid_text, o_sop, o_eop,
           o_tag_ok, o_tag_fail, o_overflow, o_abort, o_busy
  );

  modport master (
    output i_valid, i_sop, i_plaintext_words_x, i_valid_text,
           i_calc_tag, i_calc_tag_valid, i_rx_tag, i_rx_tag_valid,
    input  o_plaintext_words_y, o_valid_text, o_sop, o_eop,
           o_tag_ok, o_tag_fail, o_overflow, o_abort, o_busy
  );
endinterface

// File: rtl/gcm_tag_check_buffer.sv
// Holds one GCM frame of plaintext until its tag is verified, then releases or discards it.
// Define GCM_TAG_CHECK_ZEROIZE_EN to wipe the whole buffer on a failed frame.
module gcm_tag_check_buffer #(
  parameter int NB_BLOCK   = 128,
  parameter int N_BLOCKS   = 2,
  parameter int NB_DATA    = N_BLOCKS * NB_BLOCK,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  gcm_tag_check_buffer_if.slave bus
);
  // state   | meaning
  // IDLE    | waiting for i_sop
  // COLLECT | storing words, capturing tags
  // CHECK   | comparing tags
  // RELEASE | streaming stored words out
  // FLUSH   | discarding the frame
  localparam int                DEPTH  = 2 ** LOG2_DEPTH;
  localparam int                NB_PTR = LOG2_DEPTH + 1;
  localparam logic [NB_PTR-1:0] FULL   = NB_PTR'(DEPTH);
  localparam logic [NB_PTR-1:0] ONE    = NB_PTR'(1);
`ifdef GCM_TAG_CHECK_ZEROIZE_EN
  localparam logic [NB_PTR-1:0] LAST   = NB_PTR'(DEPTH - 1);
`endif

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, RELEASE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  mem_q [DEPTH];
  logic [NB_PTR-1:0]   cnt_q, cnt_d, rptr_q, rptr_d;
  logic [NB_BLOCK-1:0] calc_tag_q, calc_tag_d, rx_tag_q, rx_tag_d;
  logic                calc_held_q, calc_held_d, rx_held_q, rx_held_d;
  logic                ovf_q, ovf_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic                valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                ok_q, ok_d, fail_q, fail_d, abort_q, abort_d;
  logic                we;
  logic [LOG2_DEPTH-1:0] waddr;
  logic [NB_DATA-1:0]  wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rptr_d      = rptr_q;
    calc_tag_d  = calc_tag_q;
    rx_tag_d    = rx_tag_q;
    calc_held_d = calc_held_q;
    rx_held_d   = rx_held_q;
    ovf_d       = ovf_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    ok_d        = 1'b0;
    fail_d      = 1'b0;
    abort_d     = 1'b0;
    we          = 1'b0;
    waddr       = cnt_q[LOG2_DEPTH-1:0];
    wdata       = bus.i_plaintext_words_x;
    case (state_q)
      IDLE, COLLECT: begin
        if (bus.i_sop) begin
          abort_d     = (state_q == COLLECT);
          state_d     = COLLECT;
          we          = bus.i_valid_text;
          waddr       = '0;
          cnt_d       = {{LOG2_DEPTH{1'b0}}, bus.i_valid_text};
          calc_held_d = 1'b0;
          rx_held_d   = 1'b0;
          ovf_d       = 1'b0;
        end else if (state_q == COLLECT) begin
          if (bus.i_valid_text) begin
            if (cnt_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              we    = 1'b1;
              cnt_d = cnt_q + ONE;
            end
          end
          if (bus.i_calc_tag_valid) begin
            calc_tag_d  = bus.i_calc_tag;
            calc_held_d = 1'b1;
          end
          if (bus.i_rx_tag_valid) begin
            rx_tag_d  = bus.i_rx_tag;
            rx_held_d = 1'b1;
          end
          if (calc_held_d && rx_held_d) state_d = CHECK;
        end
      end
      CHECK: begin
        rptr_d = '0;
        if ((calc_tag_q == rx_tag_q) && !ovf_q) begin
          ok_d    = 1'b1;
          state_d = RELEASE;
          // word 0 leaves together with the verdict
          if (cnt_q != '0) begin
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (cnt_q == ONE);
            data_d  = mem_q[0];
            rptr_d  = ONE;
          end
        end else begin
          fail_d  = 1'b1;
          state_d = FLUSH;
        end
      end
      RELEASE: begin
        if (rptr_q < cnt_q) begin
          valid_d = 1'b1;
          eop_d   = (rptr_q == cnt_q - ONE);
          data_d  = mem_q[rptr_q[LOG2_DEPTH-1:0]];
          rptr_d  = rptr_q + ONE;
          if (eop_d) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
`ifdef GCM_TAG_CHECK_ZEROIZE_EN
        we     = 1'b1;
        waddr  = rptr_q[LOG2_DEPTH-1:0];
        wdata  = '0;
        rptr_d = rptr_q + ONE;
        if (rptr_q == LAST) begin
          state_d = IDLE;
          rptr_d  = '0;
          cnt_d   = '0;
        end
`else
        rptr_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rptr_q      <= '0;
      calc_tag_q  <= '0;
      rx_tag_q    <= '0;
      calc_held_q <= 1'b0;
      rx_held_q   <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else if (bus.i_valid) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rptr_q      <= rptr_d;
      calc_tag_q  <= calc_tag_d;
      rx_tag_q    <= rx_tag_d;
      calc_held_q <= calc_held_d;
      rx_held_q   <= rx_held_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      abort_q     <= abort_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && bus.i_valid && we) mem_q[waddr] <= wdata;
  end

  // pulses are qualified by the live enable so a stalled pulse is seen only once
  assign bus.o_plaintext_words_y = data_q;
  assign bus.o_valid_text        = valid_q & bus.i_valid;
  assign bus.o_sop               = sop_q & bus.i_valid;
  assign bus.o_eop               = eop_q & bus.i_valid;
  assign bus.o_tag_ok            = ok_q & bus.i_valid;
  assign bus.o_tag_fail          = fail_q & bus.i_valid;
  assign bus.o_abort             = abort_q & bus.i_valid;
  assign bus.o_overflow          = ovf_q;
  assign bus.o_busy              = (state_q == CHECK) || (state_q == RELEASE) || (state_q == FLUSH);
endmodule
